mem_pwr_ctrl: RTL
=================

MEM_PWR_CTRL -- requirements
Module: mem_pwr_ctrl

Interface
REQ-001 Parameter AddrWidth, default 14: byte-address width of the upstream memory port.
REQ-002 Parameter DataWidth, default 64: data width in bits; byte-strobe width is DataWidth/8.
REQ-003 Parameter NumWords, default 8192: SRAM depth in words.
REQ-004 Parameter IdleCycles, default 64: idle cycles in ON before entering RET; 0 disables retention.
REQ-005 clk_i  in  1  clock, rising edge.
REQ-006 rst_ni  in  1  reset, asynchronous, active-low.
REQ-007 mem_req_i / mem_we_i  in  1 each  upstream request and write enable.
REQ-008 mem_gnt_o  out  1  upstream grant.
REQ-009 mem_addr_i  in  AddrWidth  upstream byte address.
REQ-010 mem_wdata_i / mem_strb_i  in  DataWidth / DataWidth/8  write data and byte strobes.
REQ-011 mem_rvalid_o / mem_rdata_o  out  1 / DataWidth  response valid and read data.
REQ-012 sleep_i  in  1  software request for full power-off (level).
REQ-013 sram_req_o / sram_we_o  out  1 each  SRAM request and write enable.
REQ-014 sram_addr_o  out  $clog2(NumWords)  SRAM word address.
REQ-015 sram_wdata_o / sram_be_o  out  DataWidth / DataWidth/8  SRAM write data and byte enables.
REQ-016 sram_rdata_i  in  DataWidth  SRAM read data.
REQ-017 sram_pwrgate_no / sram_set_retentive_no  out  1 each  power gate (0 = off) and retention (0 = retain).
REQ-018 sram_pwrgate_ack_ni  in  1  power acknowledge; 1 = powered and usable.
REQ-019 pwr_state_o  out  3  current FSM state encoding.

Function
REQ-020 FSM states: ON, RET, PD (powering down), OFF, PU (powering up).
REQ-021 mem_gnt_o SHALL equal mem_req_i in ON and SHALL be 0 in every other state.
REQ-022 sram_req_o = mem_req_i & mem_gnt_o; we/wdata forwarded; sram_be_o = mem_strb_i; sram_addr_o = mem_addr_i[$clog2(NumWords)+2:3].
REQ-023 mem_rvalid_o SHALL be registered sram_req_o (reads and writes), asserted exactly 1 cycle after grant; mem_rdata_o = sram_rdata_i.
REQ-024 Idle counter: increments in ON when mem_req_i=0 and mem_rvalid_o=0, clears on any request or outside ON, saturates at IdleCycles.
REQ-025 ON -> RET when counter reaches IdleCycles (IdleCycles>0) and sleep_i=0.
REQ-026 ON -> PD when sleep_i=1, mem_req_i=0 and mem_rvalid_o=0; sleep has priority over retention.
REQ-027 In ON, mem_req_i=1 SHALL block every exit, including simultaneous sleep_i or timeout.
REQ-028 RET: sram_set_retentive_no=0; mem_req_i=1 -> ON (1-cycle exit, granted next cycle); sleep_i=1 without request -> PD.
REQ-029 PD: sram_pwrgate_no=0, retentive high; -> OFF when sram_pwrgate_ack_ni=0.
REQ-030 OFF: sram_pwrgate_no=0; -> PU when mem_req_i=1 or sleep_i=0.
REQ-031 PU: sram_pwrgate_no=1; -> ON when sram_pwrgate_ack_ni=1; request held ungranted meanwhile.
REQ-032 Contents after OFF are undefined; no data restoration is performed.
REQ-033 sram_set_retentive_no=1 and sram_pwrgate_no=1 in ON.

Reset
REQ-034 Reset SHALL force ON, idle counter 0, mem_rvalid_o=0, sram_pwrgate_no=1, sram_set_retentive_no=1.
REQ-035 Reset asserted mid-PD/PU SHALL abort the sequence; after release the block is in ON, and requests are granted only while sram_pwrgate_ack_ni=1 (ON waits on ack low via PU path: ON with ack=0 -> PU).

Structure
REQ-036 The state enum mem_pwr_state_e (3 bits) SHALL live in core_v_mcu_pkg; no other shared types.
REQ-037 Single module; idle counter and FSM inline, no sub-module.
REQ-038 mem_pwr_ctrl SHALL sit between axi_to_mem and sram_wrapper inside the memory subsystem, replacing the constant grant, rvalid register and tied-off power/strobe pins.

Verification (IdleCycles=16)
REQ-039 Write 0xDEADBEEF_CAFEF00D to addr 0x40, strb 0x0F, read back -> rvalid 1 cycle after each grant, rdata 0xXXXXXXXX_CAFEF00D with upper bytes unchanged.
REQ-040 16 idle cycles -> RET, retentive_no=0; request at cycle 20 -> gnt at 21, prior data intact.
REQ-041 sleep_i=1, ack falls 5 cycles later -> PD then OFF; request -> PU, gnt only after ack rises 7 cycles later.
REQ-042 sleep_i and mem_req_i asserted same cycle in ON -> request granted, state stays ON, PD entered next idle cycle.
REQ-043 rst_ni pulsed during PU with ack=0 -> no grant until ack=1, then normal operation.

Source files
------------

// File: rtl/core_v_mcu_pkg.sv
// Shared types for the core-v-mcu memory subsystem.
package core_v_mcu_pkg;

    typedef enum logic [2:0] {
        PwrOn  = 3'd0,
        PwrRet = 3'd1,
        PwrPd  = 3'd2,
        PwrOff = 3'd3,
        PwrPu  = 3'd4
    } mem_pwr_state_e;

endpackage

// File: rtl/mem_pwr_ctrl.sv
// SRAM power controller between the memory port and the SRAM macro:
// grants requests when powered, and handles retention and full power-off.
module mem_pwr_ctrl
    import core_v_mcu_pkg::*;
#(
    parameter int unsigned AddrWidth  = 14,
    parameter int unsigned DataWidth  = 64,
    parameter int unsigned NumWords   = 8192,
    parameter int unsigned IdleCycles = 64
) (
    input  logic                         clk_i,
    input  logic                         rst_ni,
    input  logic                         mem_req_i,
    input  logic                         mem_we_i,
    output logic                         mem_gnt_o,
    input  logic [AddrWidth-1:0]         mem_addr_i,
    input  logic [DataWidth-1:0]         mem_wdata_i,
    input  logic [DataWidth/8-1:0]       mem_strb_i,
    output logic                         mem_rvalid_o,
    output logic [DataWidth-1:0]         mem_rdata_o,
    input  logic                         sleep_i,
    output logic                         sram_req_o,
    output logic                         sram_we_o,
    output logic [$clog2(NumWords)-1:0]  sram_addr_o,
    output logic [DataWidth-1:0]         sram_wdata_o,
    output logic [DataWidth/8-1:0]       sram_be_o,
    input  logic [DataWidth-1:0]         sram_rdata_i,
    output logic                         sram_pwrgate_no,
    output logic                         sram_set_retentive_no,
    input  logic                         sram_pwrgate_ack_ni,
    output logic [2:0]                   pwr_state_o
);

    localparam int unsigned SramAw = $clog2(NumWords);
    localparam int unsigned CntW   = (IdleCycles > 0) ? $clog2(IdleCycles + 1) : 1;
    localparam logic [CntW-1:0] CntMax = CntW'(IdleCycles);

    mem_pwr_state_e  state_q, state_d;
    logic [CntW-1:0] idle_cnt_q;
    logic            rvalid_q;
    logic            idle;
    logic [SramAw+AddrWidth+2:0] addr_ext;

    // Zero-extend so the word slice stays legal when the byte address is narrower than the SRAM.
    assign addr_ext = {{(SramAw+3){1'b0}}, mem_addr_i};

    assign mem_gnt_o    = (state_q == PwrOn) && sram_pwrgate_ack_ni && mem_req_i;
    assign sram_req_o   = mem_req_i & mem_gnt_o;
    assign sram_we_o    = mem_we_i;
    assign sram_wdata_o = mem_wdata_i;
    assign sram_be_o    = mem_strb_i;
    assign sram_addr_o  = addr_ext[SramAw+2:3];
    assign mem_rvalid_o = rvalid_q;
    assign mem_rdata_o  = sram_rdata_i;
    assign pwr_state_o  = state_q;
    assign idle         = ~mem_req_i & ~rvalid_q;

    assign sram_pwrgate_no       = !((state_q == PwrPd) || (state_q == PwrOff));
    assign sram_set_retentive_no = (state_q != PwrRet);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= PwrOn;
            idle_cnt_q <= '0;
            rvalid_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            rvalid_q <= sram_req_o;
            if ((state_q != PwrOn) || !idle) begin
                idle_cnt_q <= '0;
            end else if (idle_cnt_q != CntMax) begin
                idle_cnt_q <= idle_cnt_q + 1'b1;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            PwrOn: begin
                // An unacknowledged macro (e.g. reset mid power-up) must finish powering up first.
                if (!sram_pwrgate_ack_ni) begin
                    state_d = PwrPu;
                end else if (idle && sleep_i) begin
                    state_d = PwrPd;
                end else if (idle && (IdleCycles > 0) && (idle_cnt_q == CntMax)) begin
                    state_d = PwrRet;
                end
            end
            PwrRet: begin
                if (mem_req_i) begin
                    state_d = PwrOn;
                end else if (sleep_i) begin
                    state_d = PwrPd;
                end
            end
            PwrPd: begin
                if (!sram_pwrgate_ack_ni) begin
                    state_d = PwrOff;
                end
            end
            PwrOff: begin
                if (mem_req_i || !sleep_i) begin
                    state_d = PwrPu;
                end
            end
            PwrPu: begin
                if (sram_pwrgate_ack_ni) begin
                    state_d = PwrOn;
                end
            end
            default: state_d = PwrOn;
        endcase
    end

endmodule
